// File: rtl/lcd1602_frame_scheduler.sv
// lcd1602_frame_scheduler: writable 2x16 frame buffer feeding an LCD1602 item stream.
// Runs the power-on init sequence, then re-sends only lines whose content changed.
`timescale 1ns/1ps
module lcd1602_frame_scheduler #(
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter logic [7:0] FUNC_SET   = 8'h38,
    parameter logic [7:0] DISP_CTRL  = 8'h0C,
    parameter logic [7:0] ENTRY_MODE = 8'h06
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       clr,
    output logic       busy,
    output logic       init_done,
    output logic       lcd_cmd,
    output logic [7:0] lcd_dat,
    output logic       lcd_vld,
    output logic       lcd_lwt,
    input  logic       lcd_ready
);
    typedef enum logic [2:0] {INIT, IDLE, ADDR1, LINE1, ADDR2, LINE2} state_t;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       dirty1_q, dirty1_d, dirty2_q, dirty2_d, done_q, done_d;
    logic       vld_q, vld_d, cmd_q, cmd_d, lwt_q, lwt_d;
    logic [7:0] dat_q, dat_d;
    logic [7:0] buf_q [32];
    logic       xfer, load, line2, wr1, wr2, item_cmd, item_lwt;
    logic [7:0] item_dat, init_dat;

    assign xfer     = vld_q & lcd_ready;
    assign load     = ~vld_q & lcd_ready & (state_q != IDLE);
    assign line2    = (state_q == ADDR2) | (state_q == LINE2);
    assign wr1      = wr_en & ~clr & ~wr_addr[4];
    assign wr2      = wr_en & ~clr & wr_addr[4];
    assign init_dat = cnt_q[1] ? (cnt_q[0] ? ENTRY_MODE : 8'h01) : (cnt_q[0] ? DISP_CTRL : FUNC_SET);
    assign item_cmd = (state_q != LINE1) & (state_q != LINE2);
    assign item_lwt = (state_q == INIT) & (cnt_q[1:0] == 2'd2);
    // Line bytes are read at load time so the newest buffer content goes out.
    assign item_dat = state_q == INIT  ? init_dat :
                      state_q == ADDR1 ? 8'h80 :
                      state_q == ADDR2 ? 8'hC0 : buf_q[{line2, cnt_q}];

    assign busy      = (state_q != IDLE) | dirty1_q | dirty2_q | vld_q;
    assign init_done = done_q;
    assign lcd_cmd   = cmd_q;
    assign lcd_dat   = dat_q;
    assign lcd_vld   = vld_q;
    assign lcd_lwt   = lwt_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        vld_d    = vld_q & ~lcd_ready;
        cmd_d    = load ? item_cmd : cmd_q;
        dat_d    = load ? item_dat : dat_q;
        lwt_d    = load ? item_lwt : lwt_q;
        // A host write on the clearing edge keeps the line dirty.
        dirty1_d = clr | wr1 | (dirty1_q & ~(load & (state_q == ADDR1)));
        dirty2_d = clr | wr2 | (dirty2_q & ~(load & (state_q == ADDR2)));
        if (load) vld_d = 1'b1;
        if (state_q == IDLE) state_d = dirty1_q ? ADDR1 : dirty2_q ? ADDR2 : IDLE;
        if (xfer) begin
            cnt_d = cnt_q + 4'd1;
            case (state_q)
                INIT: if (cnt_q == 4'd3) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
                ADDR1: begin
                    state_d = LINE1;
                    cnt_d   = '0;
                end
                ADDR2: begin
                    state_d = LINE2;
                    cnt_d   = '0;
                end
                LINE1, LINE2: if (cnt_q == 4'd15) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            dirty1_q <= 1'b1;
            dirty2_q <= 1'b1;
            vld_q    <= 1'b0;
            cmd_q    <= 1'b0;
            dat_q    <= '0;
            lwt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            dirty1_q <= dirty1_d;
            dirty2_q <= dirty2_d;
            vld_q    <= vld_d;
            cmd_q    <= cmd_d;
            dat_q    <= dat_d;
            lwt_q    <= lwt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            for (int i = 0; i < 32; i++) buf_q[i] <= BLANK_CHAR;
        end else if (wr_en) begin
            buf_q[wr_addr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_lcd1602_frame_scheduler.sv
// tb_lcd1602_frame_scheduler: directed tests of init, dirty-line refresh, stall, clr and async reset.
`timescale 1ns/1ps
module tb_lcd1602_frame_scheduler;
    logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, clr = 1'b0, lcd_ready = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       busy, init_done, lcd_cmd, lcd_vld, lcd_lwt;
    logic [7:0] lcd_dat;
    int         pass_cnt = 0, total_cnt = 0, base = 0;
    logic [9:0] got_q[$], exp_q[$];
    logic       idn_q[$];
    logic [7:0] mbuf [32];

    lcd1602_frame_scheduler dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr(clr), .busy(busy), .init_done(init_done), .lcd_cmd(lcd_cmd),
        .lcd_dat(lcd_dat), .lcd_vld(lcd_vld), .lcd_lwt(lcd_lwt), .lcd_ready(lcd_ready)
    );

    always #5 clk = ~clk;

    // Items are logged as {cmd, dat, lwt} on the half-cycle before they transfer.
    always @(negedge clk) begin
        if (lcd_vld && lcd_ready) begin
            got_q.push_back({lcd_cmd, lcd_dat, lcd_lwt});
            idn_q.push_back(init_done);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        step(1);
    endtask

    task automatic wait_items(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            ok = got_q.size() >= n;
        end
        step(1);
    endtask

    task automatic blank_model();
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    endtask

    task automatic push_init();
        exp_q.push_back({1'b1, 8'h38, 1'b0});
        exp_q.push_back({1'b1, 8'h0C, 1'b0});
        exp_q.push_back({1'b1, 8'h01, 1'b1});
        exp_q.push_back({1'b1, 8'h06, 1'b0});
    endtask

    task automatic push_line(input int l);
        exp_q.push_back({1'b1, (l == 1) ? 8'hC0 : 8'h80, 1'b0});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, mbuf[l * 16 + i], 1'b0});
    endtask

    task automatic write_byte(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        step(1);
        wr_en = 1'b0;
        mbuf[a] = d;
    endtask

    task automatic test_reset();
        step(2);
        total_cnt += 6;
        if (lcd_vld !== 1'b0) $display("FAIL reset lcd_vld got %b exp 0", lcd_vld); else pass_cnt++;
        if (busy !== 1'b1) $display("FAIL reset busy got %b exp 1", busy); else pass_cnt++;
        if (init_done !== 1'b0) $display("FAIL reset init_done got %b exp 0", init_done); else pass_cnt++;
        if (lcd_cmd !== 1'b0) $display("FAIL reset lcd_cmd got %b exp 0", lcd_cmd); else pass_cnt++;
        if (lcd_dat !== 8'h00) $display("FAIL reset lcd_dat got %h exp 00", lcd_dat); else pass_cnt++;
        if (lcd_lwt !== 1'b0) $display("FAIL reset lcd_lwt got %b exp 0", lcd_lwt); else pass_cnt++;
    endtask

    task automatic test_init();
        bit ok;
        blank_model();
        exp_q.delete();
        push_init();
        push_line(0);
        push_line(1);
        lcd_ready = 1'b1;
        base = got_q.size();
        rst = 1'b0;
        wait_idle(ok);
        total_cnt += 4;
        if (!ok) $display("FAIL init idle timeout got busy %b exp 0", busy); else pass_cnt++;
        if (init_done !== 1'b1) $display("FAIL init init_done got %b exp 1", init_done); else pass_cnt++;
        if (got_q.size() - base !== exp_q.size())
            $display("FAIL init count got %0d exp %0d", got_q.size() - base, exp_q.size());
        else pass_cnt++;
        if (got_q.size() - base < 5 || idn_q[base + 3] !== 1'b0 || idn_q[base + 4] !== 1'b1)
            $display("FAIL init init_done_timing got items %0d exp rise after item 3", got_q.size() - base);
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL init item %0d got %h exp %h", i, got_q[base + i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_idle_write();
        bit ok;
        base = got_q.size();
        write_byte(5'd3, 8'h41);
        exp_q.delete();
        push_line(0);
        wait_idle(ok);
        total_cnt += 2;
        if (!ok) $display("FAIL idle_write timeout got busy %b exp 0", busy); else pass_cnt++;
        if (got_q.size() - base !== 17) $display("FAIL idle_write count got %0d exp 17", got_q.size() - base);
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL idle_write item %0d got %h exp %h", i, got_q[base + i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        base = got_q.size();
        write_byte(5'd5, 8'h42);
        write_byte(5'd20, 8'h43);
        exp_q.delete();
        push_line(0);
        push_line(1);
        wait_idle(ok);
        total_cnt += 2;
        if (!ok) $display("FAIL back_to_back timeout got busy %b exp 0", busy); else pass_cnt++;
        if (got_q.size() - base !== 34) $display("FAIL back_to_back count got %0d exp 34", got_q.size() - base);
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL back_to_back item %0d got %h exp %h", i, got_q[base + i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_line_write();
        bit ok, ok2;
        base = got_q.size();
        write_byte(5'd1, 8'h61);
        exp_q.delete();
        push_line(0);
        wait_items(base + 9, ok);
        write_byte(5'd2, 8'h5A);
        push_line(0);
        wait_idle(ok2);
        total_cnt += 3;
        if (!ok) $display("FAIL mid_line reach_col8 got items %0d exp 9", got_q.size() - base); else pass_cnt++;
        if (!ok2) $display("FAIL mid_line timeout got busy %b exp 0", busy); else pass_cnt++;
        if (got_q.size() - base !== 34) $display("FAIL mid_line count got %0d exp 34", got_q.size() - base);
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL mid_line item %0d got %h exp %h", i, got_q[base + i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        bit ok, stable;
        lcd_ready = 1'b0;
        base = got_q.size();
        write_byte(5'd17, 8'h44);
        exp_q.delete();
        push_line(1);
        step(2);
        lcd_ready = 1'b1;
        step(1);
        lcd_ready = 1'b0;
        total_cnt += 1;
        if ({lcd_vld, lcd_cmd, lcd_dat} !== {2'b11, 8'hC0})
            $display("FAIL stall present got vld/cmd/dat %b/%b/%h exp 1/1/c0", lcd_vld, lcd_cmd, lcd_dat);
        else pass_cnt++;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if ({lcd_vld, lcd_cmd, lcd_dat, lcd_lwt} !== {2'b11, 8'hC0, 1'b0}) stable = 1'b0;
        end
        total_cnt += 1;
        if (!stable) $display("FAIL stall hold got vld/cmd/dat %b/%b/%h exp 1/1/c0", lcd_vld, lcd_cmd, lcd_dat);
        else pass_cnt++;
        lcd_ready = 1'b1;
        step(1);
        lcd_ready = 1'b0;
        total_cnt += 3;
        if (lcd_vld !== 1'b0) $display("FAIL stall vld_fall got %b exp 0", lcd_vld); else pass_cnt++;
        step(3);
        if (lcd_vld !== 1'b0) $display("FAIL stall vld_low got %b exp 0", lcd_vld); else pass_cnt++;
        if (got_q.size() - base !== 1) $display("FAIL stall one_xfer got %0d exp 1", got_q.size() - base);
        else pass_cnt++;
        lcd_ready = 1'b1;
        wait_idle(ok);
        total_cnt += 2;
        if (!ok) $display("FAIL stall timeout got busy %b exp 0", busy); else pass_cnt++;
        if (got_q.size() - base !== 17) $display("FAIL stall count got %0d exp 17", got_q.size() - base);
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL stall item %0d got %h exp %h", i, got_q[base + i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_clr();
        bit ok;
        base = got_q.size();
        clr = 1'b1;
        wr_en = 1'b1;
        wr_addr = 5'd0;
        wr_data = 8'h58;
        step(1);
        clr = 1'b0;
        wr_en = 1'b0;
        blank_model();
        exp_q.delete();
        push_line(0);
        push_line(1);
        wait_idle(ok);
        total_cnt += 2;
        if (!ok) $display("FAIL clr timeout got busy %b exp 0", busy); else pass_cnt++;
        if (got_q.size() - base !== 34) $display("FAIL clr count got %0d exp 34", got_q.size() - base);
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL clr item %0d got %h exp %h", i, got_q[base + i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_rst_mid_line();
        bit ok, seen;
        base = got_q.size();
        write_byte(5'd18, 8'h45);
        wait_items(base + 5, ok);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            seen = lcd_vld;
            if (!seen) step(1);
        end
        #2;
        rst = 1'b1;
        #1;
        total_cnt += 5;
        if (!(ok && seen)) $display("FAIL rst_mid reach_line2 got items %0d exp 5", got_q.size() - base); else pass_cnt++;
        if (lcd_vld !== 1'b0) $display("FAIL rst_mid async_vld got %b exp 0", lcd_vld); else pass_cnt++;
        if (busy !== 1'b1) $display("FAIL rst_mid busy got %b exp 1", busy); else pass_cnt++;
        if (init_done !== 1'b0) $display("FAIL rst_mid init_done got %b exp 0", init_done); else pass_cnt++;
        if (lcd_dat !== 8'h00) $display("FAIL rst_mid lcd_dat got %h exp 00", lcd_dat); else pass_cnt++;
        step(2);
        base = got_q.size();
        rst = 1'b0;
        blank_model();
        exp_q.delete();
        push_init();
        push_line(0);
        push_line(1);
        wait_idle(ok);
        total_cnt += 2;
        if (!ok) $display("FAIL rst_mid timeout got busy %b exp 0", busy); else pass_cnt++;
        if (got_q.size() - base !== 38) $display("FAIL rst_mid count got %0d exp 38", got_q.size() - base);
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL rst_mid item %0d got %h exp %h", i, got_q[base + i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_idle_write();
        test_back_to_back();
        test_mid_line_write();
        test_stall();
        test_clr();
        test_rst_mid_line();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/lcd1602_frame_scheduler.md
Name: lcd1602_frame_scheduler

Overview:
- Owns a 32-byte character frame buffer (2 lines x 16) that host logic writes at any time.
- Sequences the 4-entry-per-item (cmd/dat/vld/lwt) stream of the LCD1602 controller: power-on init first, then re-sends only the lines whose content changed.
- Sits between application logic and the LCD1602 controller. It replaces hard-coded ROM sequencers with a writable display.

Parameters:
- BLANK_CHAR, 8'h20, character loaded into every buffer byte at reset and on clr.
- FUNC_SET, 8'h38, first init instruction (8-bit bus, 2 lines, 5x8 font).
- DISP_CTRL, 8'h0C, second init instruction (display on, cursor off).
- ENTRY_MODE, 8'h06, fourth init instruction (increment, no shift).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  host write strobe, one byte per cycle
- wr_addr  in  5  buffer index: 0-15 line 1, 16-31 line 2
- wr_data  in  8  character code
- clr  in  1  single-cycle pulse: fill buffer with BLANK_CHAR
- busy  out  1  high while any item is pending or in flight
- init_done  out  1  sticky high once the init sequence is accepted
- lcd_cmd  out  1  1 = instruction, 0 = data character
- lcd_dat  out  8  instruction/character byte
- lcd_vld  out  1  item valid
- lcd_lwt  out  1  long-wait item (clear-display only)
- lcd_ready  in  1  LCD controller ready

Behaviour:
- Reset (asynchronous): lcd_vld=0, lcd_cmd=0, lcd_dat=0, lcd_lwt=0, busy=1, init_done=0, all buffer bytes=BLANK_CHAR, dirty1=dirty2=1, state=INIT, item index=0.
- Handshake: an item transfers on a clk edge where lcd_vld & lcd_ready=1.
  - lcd_cmd, lcd_dat and lcd_lwt are registered and stable from lcd_vld rise until transfer.
  - lcd_vld falls the cycle after transfer and stays low at least one cycle.
  - The next item is presented (lcd_vld rises) on the cycle after lcd_ready is sampled high while lcd_vld is low. This gives 1-cycle issue latency.
  - The block never drops lcd_vld before transfer.
- State INIT: issues {cmd=1,FUNC_SET}, {1,DISP_CTRL}, {1,8'h01,lwt=1}, {1,ENTRY_MODE} in order. After the 4th transfer, init_done=1 and the next state is IDLE.
- State IDLE: if dirty1, go to ADDR1; else if dirty2, go to ADDR2; else stay, with busy=0. Line 1 has priority.
- ADDR1: issues {1,8'h80}. dirty1 clears on the same edge the item is loaded into the output registers. Next state LINE1, column=0.
- LINE1: issues {0,buf[column]} for columns 0..15. The byte is sampled from the buffer when loaded, so the latest write is used. After column 15 transfers, go to IDLE. Column counter is 4 bits; no wrap past 15.
- ADDR2/LINE2: same as ADDR1/LINE1 with 8'hC0, buf[16+column] and dirty2.
- busy=1 in every state except IDLE with both dirty flags clear and lcd_vld=0.
- Host write: buf[wr_addr] <= wr_data and sets dirty1 (addr<16) or dirty2 (addr>=16). Writes are accepted every cycle in every state, including INIT.
  - A write to a line currently being sent re-sets that line's dirty flag, so the whole line is re-sent afterwards.
  - A write and a dirty-clear on the same edge: the set wins.
- clr: all 32 bytes <= BLANK_CHAR and both dirty flags set in one cycle. clr and wr_en in the same cycle: clr wins, and the write is dropped.
- lcd_lwt=1 only on the init clear instruction; 0 for every other item.
- rst asserted mid-transfer: outputs return to reset values immediately and the init sequence restarts after release.

Test Plan:
- Release reset with lcd_ready held 1 -> items in order 138(lwt=0), 10C, 101(lwt=1), 106, then 180 plus sixteen {0,20}, then 1C0 plus sixteen {0,20}. init_done rises after the 106 transfer; busy falls after the final item.
- Idle, write addr 3=8'h41 -> exactly 17 items, 180 then line-1 bytes with 41 at column 3. Line 2 is not sent.
- Write addr 5 and addr 20 in the same idle period -> line 1 (180 + 16 bytes) is sent, then line 2 (1C0 + 16 bytes).
- While LINE1 is at column 8, write addr 2=8'h5A -> current pass completes, then line 1 is re-sent with 5A at column 2.
- Hold lcd_ready=0 for 50 cycles with lcd_vld high -> lcd_cmd/lcd_dat/lcd_vld stay constant. After lcd_ready=1, exactly one transfer, then lcd_vld is low for 1 or more cycles.
- clr and wr_en (addr 0, 8'h58) in the same cycle -> both lines are re-sent, all bytes 20. Assert rst mid-line-2 -> lcd_vld=0 asynchronously, and the sequence restarts with 138.
